axi4_lite_led_slave: RTL and testbench

//  AXI4-Lite responder (subordinate) at the far end of the SoC's AXI4-Lite bus; it terminates master transactions issued from the MEM stage.

---
 rtl/axi4_lite_led_slave_pkg.sv | 41 ++++
 rtl/axi4_lite_slv_regs.sv | 75 +++++++
 rtl/axi4_lite_led_slave.sv | 193 +++++++++++++++++++
 tb/tb_axi4_lite_led_slave.sv | 443 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi4_lite_led_slave_pkg.sv
// -----------------------------------------------------------------------------
// axi4_lite_led_slave_pkg
//   Shared definitions for the AXI4-Lite LED responder:
//   - AXI response codes (RESP_OKAY, RESP_SLVERR)
//   - register word offsets (addr[3:2]) REG_CTRL / REG_SCRATCH / REG_CYCLE / REG_ID
//   - write / read channel FSM state encodings
//   - strb_merge(): byte-lane merge of write data into an old register value
// -----------------------------------------------------------------------------
package axi4_lite_led_slave_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [1:0] REG_CTRL    = 2'd0;
    localparam logic [1:0] REG_SCRATCH = 2'd1;
    localparam logic [1:0] REG_CYCLE   = 2'd2;
    localparam logic [1:0] REG_ID      = 2'd3;

    typedef enum logic {
        W_IDLE = 1'b0,
        W_RESP = 1'b1
    } w_state_e;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } r_state_e;

    // Replace each byte of old_val whose strobe bit is set.
    function automatic logic [31:0] strb_merge(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) res[8*b +: 8] = new_val[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/axi4_lite_slv_regs.sv
// -----------------------------------------------------------------------------
// axi4_lite_slv_regs
//   Register bank behind the AXI4-Lite LED responder.
//   Ports:
//     clk, rst        clock, synchronous active-high reset
//     wr_en           commit one write this cycle (already decoded as a hit)
//     wr_sel          target word (addr[3:2])
//     wr_data/wr_strb write data and byte strobes
//     rd_sel          word selected by the read mux (addr[3:2])
//     rd_data         combinational read of the current register values
//     led             CTRL[0]
//   CYCLE counts every clock and wraps; CYCLE and ID ignore writes.
// -----------------------------------------------------------------------------
module axi4_lite_slv_regs
    import axi4_lite_led_slave_pkg::*;
#(
    parameter logic [31:0] ID_VALUE = 32'h5256_4C54
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [1:0]  wr_sel,
    input  logic [31:0] wr_data,
    input  logic [3:0]  wr_strb,
    input  logic [1:0]  rd_sel,
    output logic [31:0] rd_data,
    output logic        led
);

    logic        ctrl_q,    ctrl_d;
    logic [31:0] scratch_q, scratch_d;
    logic [31:0] cycle_q,   cycle_d;

    // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        ctrl_d    = ctrl_q;
        scratch_d = scratch_q;
        cycle_d   = cycle_q + 32'd1;
        if (wr_en) begin
            case (wr_sel)
                REG_CTRL:    if (wr_strb[0]) ctrl_d = wr_data[0];
                REG_SCRATCH: scratch_d = strb_merge(scratch_q, wr_data, wr_strb);
                default:     ;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignment so all flops sample pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_q    <= 1'b0;
            scratch_q <= '0;
            cycle_q   <= '0;
        end else begin
            ctrl_q    <= ctrl_d;
            scratch_q <= scratch_d;
            cycle_q   <= cycle_d;
        end
    end

    // Reads see the pre-edge values, so a same-cycle write is not visible yet.
    always_comb begin
        rd_data = '0;
        case (rd_sel)
            REG_CTRL:    rd_data = {31'd0, ctrl_q};
            REG_SCRATCH: rd_data = scratch_q;
            REG_CYCLE:   rd_data = cycle_q;
            REG_ID:      rd_data = ID_VALUE;
            default:     rd_data = '0;
        endcase
    end

    assign led = ctrl_q;

endmodule

// File: rtl/axi4_lite_led_slave.sv
// -----------------------------------------------------------------------------
// axi4_lite_led_slave
//   AXI4-Lite responder with a 4-word register bank (CTRL, SCRATCH, CYCLE, ID)
//   driving the board LED from CTRL[0]. Write and read channels are independent,
//   one transaction outstanding each.
//   Ports:
//     clk, rst                 clock, synchronous active-high reset
//     s_aw*/s_w*/s_b*          AXI4-Lite write address / data / response
//     s_ar*/s_r*               AXI4-Lite read address / data
//     led                      CTRL[0]
//   Configuration macro AXI_SLVERR_EN: when defined, accesses outside
//   BASE_ADDR..BASE_ADDR+0xF answer SLVERR instead of OKAY.
// -----------------------------------------------------------------------------
module axi4_lite_led_slave
    import axi4_lite_led_slave_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h0000_0000,
    parameter logic [31:0]           ID_VALUE   = 32'h5256_4C54
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_WIDTH-1:0]   s_awaddr,
    input  logic                    s_awvalid,
    output logic                    s_awready,
    input  logic [DATA_WIDTH-1:0]   s_wdata,
    input  logic [DATA_WIDTH/8-1:0] s_wstrb,
    input  logic                    s_wvalid,
    output logic                    s_wready,
    output logic [1:0]              s_bresp,
    output logic                    s_bvalid,
    input  logic                    s_bready,
    input  logic [ADDR_WIDTH-1:0]   s_araddr,
    input  logic                    s_arvalid,
    output logic                    s_arready,
    output logic [DATA_WIDTH-1:0]   s_rdata,
    output logic [1:0]              s_rresp,
    output logic                    s_rvalid,
    input  logic                    s_rready,
    output logic                    led
);

`ifdef AXI_SLVERR_EN
    localparam logic [1:0] UNMAPPED_RESP = RESP_SLVERR;
`else
    localparam logic [1:0] UNMAPPED_RESP = RESP_OKAY;
`endif

    w_state_e                  w_state_q,  w_state_d;
    logic                      aw_done_q,  aw_done_d;
    logic                      w_done_q,   w_done_d;
    logic [ADDR_WIDTH-1:0]     awaddr_q,   awaddr_d;
    logic [DATA_WIDTH-1:0]     wdata_q,    wdata_d;
    logic [DATA_WIDTH/8-1:0]   wstrb_q,    wstrb_d;
    logic [1:0]                bresp_q,    bresp_d;
    r_state_e                  r_state_q,  r_state_d;
    logic [DATA_WIDTH-1:0]     rdata_q,    rdata_d;
    logic [1:0]                rresp_q,    rresp_d;

    logic                      aw_hs, w_hs, ar_hs;
    logic [ADDR_WIDTH-1:0]     wr_addr;
    logic [DATA_WIDTH-1:0]     wr_data;
    logic [DATA_WIDTH/8-1:0]   wr_strb;
    logic                      wr_hit, wr_commit, rd_hit;
    logic [31:0]               reg_rdata;
    logic                      unused_addr_lsbs;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            w_state_q <= W_IDLE;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            bresp_q   <= RESP_OKAY;
            r_state_q <= R_IDLE;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
        end else begin
            w_state_q <= w_state_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            bresp_q   <= bresp_d;
            r_state_q <= r_state_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
        end
    end

    // Handshakes; ready depends only on registered state, so no comb loop.
    assign aw_hs = s_awvalid & s_awready;
    assign w_hs  = s_wvalid  & s_wready;
    assign ar_hs = s_arvalid & s_arready;

    // The write commits on the edge where the second of AW/W arrives, using
    // either the latched copy or the value on the bus this cycle.
    assign wr_addr   = aw_done_q ? awaddr_q : s_awaddr;
    assign wr_data   = w_done_q  ? wdata_q  : s_wdata;
    assign wr_strb   = w_done_q  ? wstrb_q  : s_wstrb;
    assign wr_hit    = (wr_addr[ADDR_WIDTH-1:4]  == BASE_ADDR[ADDR_WIDTH-1:4]);
    assign rd_hit    = (s_araddr[ADDR_WIDTH-1:4] == BASE_ADDR[ADDR_WIDTH-1:4]);
    assign wr_commit = (w_state_q == W_IDLE) && (aw_done_q || aw_hs) && (w_done_q || w_hs);

    assign unused_addr_lsbs = ^{wr_addr[1:0], s_araddr[1:0]};

    // Next-state logic.
    always_comb begin
        w_state_d = w_state_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        bresp_d   = bresp_q;
        r_state_d = r_state_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;

        if (aw_hs) begin
            aw_done_d = 1'b1;
            awaddr_d  = s_awaddr;
        end
        if (w_hs) begin
            w_done_d = 1'b1;
            wdata_d  = s_wdata;
            wstrb_d  = s_wstrb;
        end

        case (w_state_q)
            W_IDLE: begin
                if (wr_commit) begin
                    w_state_d = W_RESP;
                    // Readies stay low through W_RESP via the state, so the
                    // latched flags can be cleared right away.
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    bresp_d   = wr_hit ? RESP_OKAY : UNMAPPED_RESP;
                end
            end
            W_RESP: begin
                if (s_bready) w_state_d = W_IDLE;
            end
            default: w_state_d = W_IDLE;
        endcase

        case (r_state_q)
            R_IDLE: begin
                if (ar_hs) begin
                    r_state_d = R_DATA;
                    rdata_d   = rd_hit ? reg_rdata : '0;
                    rresp_d   = rd_hit ? RESP_OKAY : UNMAPPED_RESP;
                end
            end
            R_DATA: begin
                if (s_rready) r_state_d = R_IDLE;
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    // Output logic.
    always_comb begin
        s_awready = (w_state_q == W_IDLE) && !aw_done_q;
        s_wready  = (w_state_q == W_IDLE) && !w_done_q;
        s_bvalid  = (w_state_q == W_RESP);
        s_bresp   = bresp_q;
        s_arready = (r_state_q == R_IDLE);
        s_rvalid  = (r_state_q == R_DATA);
        s_rdata   = rdata_q;
        s_rresp   = rresp_q;
    end

    axi4_lite_slv_regs #(
        .ID_VALUE (ID_VALUE)
    ) u_regs (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_commit && wr_hit),
        .wr_sel  (wr_addr[3:2]),
        .wr_data (wr_data),
        .wr_strb (wr_strb),
        .rd_sel  (s_araddr[3:2]),
        .rd_data (reg_rdata),
        .led     (led)
    );

endmodule

// File: tb/tb_axi4_lite_led_slave.sv
// -----------------------------------------------------------------------------
// tb_axi4_lite_led_slave
//   Self-checking bench for axi4_lite_led_slave. Inputs change and outputs are
//   sampled on the falling edge; the DUT acts on the rising edge. Expected
//   values come from a register-map model (ctrl bit, scratch word, cycle count)
//   kept in the bench. Honours AXI_SLVERR_EN for the unmapped response code.
// -----------------------------------------------------------------------------
module tb_axi4_lite_led_slave;

    localparam logic [31:0] ID_VALUE = 32'h5256_4C54;
`ifdef AXI_SLVERR_EN
    localparam logic [1:0] UNMAP_RESP = 2'b10;
`else
    localparam logic [1:0] UNMAP_RESP = 2'b00;
`endif

    logic        clk;
    logic        rst;
    logic [31:0] s_awaddr;
    logic        s_awvalid;
    logic        s_awready;
    logic [31:0] s_wdata;
    logic [3:0]  s_wstrb;
    logic        s_wvalid;
    logic        s_wready;
    logic [1:0]  s_bresp;
    logic        s_bvalid;
    logic        s_bready;
    logic [31:0] s_araddr;
    logic        s_arvalid;
    logic        s_arready;
    logic [31:0] s_rdata;
    logic [1:0]  s_rresp;
    logic        s_rvalid;
    logic        s_rready;
    logic        led;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state.
    logic [31:0] mdl_cycle;
    logic        mdl_ctrl;
    logic [31:0] mdl_scratch;

    axi4_lite_led_slave dut (
        .clk       (clk),
        .rst       (rst),
        .s_awaddr  (s_awaddr),
        .s_awvalid (s_awvalid),
        .s_awready (s_awready),
        .s_wdata   (s_wdata),
        .s_wstrb   (s_wstrb),
        .s_wvalid  (s_wvalid),
        .s_wready  (s_wready),
        .s_bresp   (s_bresp),
        .s_bvalid  (s_bvalid),
        .s_bready  (s_bready),
        .s_araddr  (s_araddr),
        .s_arvalid (s_arvalid),
        .s_arready (s_arready),
        .s_rdata   (s_rdata),
        .s_rresp   (s_rresp),
        .s_rvalid  (s_rvalid),
        .s_rready  (s_rready),
        .led       (led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // CYCLE is simply "clocks since reset", modulo 2^32.
    always @(posedge clk) begin
        if (rst) mdl_cycle <= 32'd0;
        else     mdl_cycle <= mdl_cycle + 32'd1;
    end

    function automatic bit mdl_hit(input logic [31:0] a);
        return a[31:4] == 28'd0;
    endfunction

    function automatic logic [1:0] mdl_resp(input logic [31:0] a);
        return mdl_hit(a) ? 2'b00 : UNMAP_RESP;
    endfunction

    task automatic mdl_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        if (mdl_hit(a)) begin
            if (a[3:2] == 2'd0 && s[0]) mdl_ctrl = d[0];
            if (a[3:2] == 2'd1) begin
                for (int b = 0; b < 4; b++)
                    if (s[b]) mdl_scratch[8*b +: 8] = d[8*b +: 8];
            end
        end
    endtask

    function automatic logic [31:0] mdl_read(input logic [31:0] a, input logic [31:0] cyc);
        if (!mdl_hit(a)) return 32'd0;
        case (a[3:2])
            2'd0:    return {31'd0, mdl_ctrl};
            2'd1:    return mdl_scratch;
            2'd2:    return cyc;
            default: return ID_VALUE;
        endcase
    endfunction

    // ---------------- bus helpers (start and end on a falling edge) ---------

    task automatic do_reset();
        rst = 1'b1;
        s_awvalid = 1'b0; s_wvalid = 1'b0; s_bready = 1'b0;
        s_arvalid = 1'b0; s_rready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        mdl_ctrl    = 1'b0;
        mdl_scratch = 32'd0;
    endtask

    // lat = falling edges waited for bvalid after the last of AW/W was taken.
    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input int aw_dly, input int w_dly,
                             input bit finish_b, output logic [1:0] resp, output int lat);
        bit aw_ok = 0;
        bit w_ok  = 0;
        bit aw_fire, w_fire;
        int n = 0;
        s_bready = 1'b0;
        while (!(aw_ok && w_ok) && n < 50) begin
            if (!aw_ok && n >= aw_dly) begin s_awvalid = 1'b1; s_awaddr = addr; end
            if (!w_ok && n >= w_dly) begin s_wvalid = 1'b1; s_wdata = data; s_wstrb = strb; end
            aw_fire = s_awvalid && s_awready;
            w_fire  = s_wvalid && s_wready;
            @(negedge clk);
            if (aw_fire) begin aw_ok = 1; s_awvalid = 1'b0; end
            if (w_fire)  begin w_ok = 1;  s_wvalid  = 1'b0; end
            n++;
        end
        if (!(aw_ok && w_ok)) begin
            miscompares++;
            $display("FAIL write_accept_timeout: addr %h not accepted within 50 cycles", addr);
            s_awvalid = 1'b0; s_wvalid = 1'b0;
        end
        lat = 0;
        while (!s_bvalid && lat < 50) begin @(negedge clk); lat++; end
        resp = s_bresp;
        if (finish_b) begin
            s_bready = 1'b1;
            @(negedge clk);
            s_bready = 1'b0;
        end
    endtask

    // cyc = CYCLE value at the AR handshake edge; lat = edges from AR to rvalid.
    task automatic axi_read(input logic [31:0] addr, output logic [31:0] data,
                            output logic [1:0] resp, output logic [31:0] cyc, output int lat);
        int n = 0;
        s_araddr = addr; s_arvalid = 1'b1; s_rready = 1'b1;
        while (!s_arready && n < 50) begin @(negedge clk); n++; end
        cyc = mdl_cycle;
        @(negedge clk);
        s_arvalid = 1'b0;
        lat = 1;
        while (!s_rvalid && lat < 50) begin @(negedge clk); lat++; end
        data = s_rdata;
        resp = s_rresp;
        @(negedge clk);
        s_rready = 1'b0;
    endtask

    // ---------------- tests ------------------------------------------------

    task automatic test_reset();
        logic [31:0] d, c;
        logic [1:0]  r;
        int          lat;
        do_reset();
        vectors++;
        if ({s_awready, s_wready, s_arready} !== 3'b111) begin
            miscompares++;
            $display("FAIL reset_ready: got %b expected 111", {s_awready, s_wready, s_arready});
        end
        vectors++;
        if ({s_bvalid, s_rvalid, led} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_valid_led: got %b expected 000", {s_bvalid, s_rvalid, led});
        end
        vectors++;
        if ({s_bresp, s_rresp, s_rdata} !== 36'd0) begin
            miscompares++;
            $display("FAIL reset_resp_rdata: got %h expected 0", {s_bresp, s_rresp, s_rdata});
        end
        axi_read(32'hC, d, r, c, lat);
        vectors++;
        if (d !== ID_VALUE || r !== 2'b00) begin
            miscompares++;
            $display("FAIL id_read: got %h/%b expected %h/00", d, r, ID_VALUE);
        end
        vectors++;
        if (lat !== 1) begin
            miscompares++;
            $display("FAIL id_read_latency: got %0d expected 1", lat);
        end
    endtask

    task automatic test_split_write();
        logic [31:0] d, c;
        logic [1:0]  r;
        int          lat;
        s_bready = 1'b0;
        s_awaddr = 32'h4; s_awvalid = 1'b1;
        @(negedge clk);
        s_awvalid = 1'b0;
        vectors++;
        if ({s_awready, s_wready, s_bvalid} !== 3'b010) begin
            miscompares++;
            $display("FAIL split_after_aw: got %b expected 010", {s_awready, s_wready, s_bvalid});
        end
        repeat (2) @(negedge clk);
        vectors++;
        if ({s_awready, s_bvalid} !== 2'b00) begin
            miscompares++;
            $display("FAIL split_waiting: got %b expected 00", {s_awready, s_bvalid});
        end
        s_wdata = 32'hDEAD_BEEF; s_wstrb = 4'hF; s_wvalid = 1'b1;
        @(negedge clk);
        s_wvalid = 1'b0;
        vectors++;
        if ({s_bvalid, s_bresp, s_awready, s_wready} !== 5'b10000) begin
            miscompares++;
            $display("FAIL split_bvalid: got %b expected 10000",
                     {s_bvalid, s_bresp, s_awready, s_wready});
        end
        mdl_write(32'h4, 32'hDEAD_BEEF, 4'hF);
        s_bready = 1'b1;
        @(negedge clk);
        s_bready = 1'b0;
        vectors++;
        if ({s_awready, s_wready, s_bvalid} !== 3'b110) begin
            miscompares++;
            $display("FAIL split_after_b: got %b expected 110", {s_awready, s_wready, s_bvalid});
        end
        axi_read(32'h4, d, r, c, lat);
        vectors++;
        if (d !== 32'hDEAD_BEEF) begin
            miscompares++;
            $display("FAIL split_readback: got %h expected deadbeef", d);
        end
    endtask

    task automatic test_strobe();
        logic [31:0] d, c;
        logic [1:0]  r;
        int          lat;
        axi_write(32'h4, 32'h1122_3344, 4'b0101, 0, 0, 1, r, lat);
        mdl_write(32'h4, 32'h1122_3344, 4'b0101);
        axi_read(32'h4, d, r, c, lat);
        vectors++;
        if (d !== 32'hDE22_BE44 || d !== mdl_scratch) begin
            miscompares++;
            $display("FAIL strobe_merge: got %h expected de22be44", d);
        end
    endtask

    task automatic test_led();
        logic [31:0] d, c;
        logic [1:0]  r;
        int          lat;
        axi_write(32'h0, 32'hFFFF_FFFF, 4'hF, 0, 0, 0, r, lat);
        mdl_write(32'h0, 32'hFFFF_FFFF, 4'hF);
        vectors++;
        if (led !== 1'b1 || lat !== 0) begin
            miscompares++;
            $display("FAIL led_on: got led=%b lat=%0d expected led=1 lat=0", led, lat);
        end
        s_bready = 1'b1; @(negedge clk); s_bready = 1'b0;
        axi_read(32'h0, d, r, c, lat);
        vectors++;
        if (d !== 32'h1) begin
            miscompares++;
            $display("FAIL ctrl_read: got %h expected 00000001", d);
        end
        axi_write(32'h0, 32'h0, 4'hF, 0, 0, 1, r, lat);
        mdl_write(32'h0, 32'h0, 4'hF);
        vectors++;
        if (led !== 1'b0) begin
            miscompares++;
            $display("FAIL led_off: got %b expected 0", led);
        end
    endtask

    task automatic test_back_pressure();
        logic [1:0] r, r0;
        int         lat;
        axi_write(32'h4, 32'hA5A5_5A5A, 4'hF, 1, 0, 0, r0, lat);
        mdl_write(32'h4, 32'hA5A5_5A5A, 4'hF);
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if ({s_bvalid, s_bresp, s_awready, s_wready} !== {1'b1, r0, 2'b00} || r0 !== 2'b00) begin
                miscompares++;
                $display("FAIL bp_hold[%0d]: got %b expected 10000", i,
                         {s_bvalid, s_bresp, s_awready, s_wready});
            end
            @(negedge clk);
        end
        s_bready = 1'b1; @(negedge clk); s_bready = 1'b0;
        vectors++;
        if ({s_awready, s_wready, s_bvalid} !== 3'b110) begin
            miscompares++;
            $display("FAIL bp_release: got %b expected 110", {s_awready, s_wready, s_bvalid});
        end
        r = r0;
    endtask

    task automatic test_unmapped();
        logic [31:0] d, c;
        logic [1:0]  r;
        int          lat;
        axi_write(32'h40, 32'hFFFF_FFFF, 4'hF, 0, 0, 1, r, lat);
        vectors++;
        if (r !== UNMAP_RESP) begin
            miscompares++;
            $display("FAIL unmapped_bresp: got %b expected %b", r, UNMAP_RESP);
        end
        axi_read(32'h40, d, r, c, lat);
        vectors++;
        if (r !== UNMAP_RESP || d !== 32'd0) begin
            miscompares++;
            $display("FAIL unmapped_read: got %h/%b expected 0/%b", d, r, UNMAP_RESP);
        end
        axi_read(32'h0, d, r, c, lat);
        vectors++;
        if (d !== {31'd0, mdl_ctrl} || led !== mdl_ctrl) begin
            miscompares++;
            $display("FAIL unmapped_no_effect: got %h led=%b expected %h", d, led, mdl_ctrl);
        end
    endtask

    task automatic test_simultaneous();
        logic [31:0] old_val, d, c;
        logic [1:0]  r;
        int          lat;
        old_val = mdl_scratch;
        s_awaddr = 32'h4; s_wdata = 32'h0BAD_F00D; s_wstrb = 4'hF;
        s_araddr = 32'h4;
        s_awvalid = 1'b1; s_wvalid = 1'b1; s_arvalid = 1'b1;
        @(negedge clk);
        s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0;
        vectors++;
        if ({s_rvalid, s_bvalid} !== 2'b11 || s_rdata !== old_val) begin
            miscompares++;
            $display("FAIL same_cycle_rw: got rdata %h valids %b expected %h 11",
                     s_rdata, {s_rvalid, s_bvalid}, old_val);
        end
        mdl_write(32'h4, 32'h0BAD_F00D, 4'hF);
        s_bready = 1'b1; s_rready = 1'b1;
        @(negedge clk);
        s_bready = 1'b0; s_rready = 1'b0;
        axi_read(32'h4, d, r, c, lat);
        vectors++;
        if (d !== mdl_scratch) begin
            miscompares++;
            $display("FAIL same_cycle_new: got %h expected %h", d, mdl_scratch);
        end
    endtask

    task automatic test_random();
        logic [31:0] addr, data, d, c;
        logic [3:0]  strb;
        logic [1:0]  r;
        int          lat;
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(3, 0) != 0)
                addr = {28'd0, 2'($urandom_range(3, 0)), 2'($urandom_range(3, 0))};
            else
                addr = $urandom | 32'h10;
            if ($urandom_range(1, 0) == 1) begin
                data = $urandom;
                strb = 4'($urandom_range(15, 0));
                axi_write(addr, data, strb, $urandom_range(3, 0), $urandom_range(3, 0), 1, r, lat);
                mdl_write(addr, data, strb);
                vectors++;
                if (r !== mdl_resp(addr) || lat !== 0) begin
                    miscompares++;
                    $display("FAIL rand_write[%0d]: addr %h got resp %b lat %0d expected %b 0",
                             i, addr, r, lat, mdl_resp(addr));
                end
            end else begin
                axi_read(addr, d, r, c, lat);
                vectors++;
                if (d !== mdl_read(addr, c) || r !== mdl_resp(addr) || lat !== 1) begin
                    miscompares++;
                    $display("FAIL rand_read[%0d]: addr %h got %h/%b lat %0d expected %h/%b 1",
                             i, addr, d, r, lat, mdl_read(addr, c), mdl_resp(addr));
                end
            end
            vectors++;
            if (led !== mdl_ctrl) begin
                miscompares++;
                $display("FAIL rand_led[%0d]: got %b expected %b", i, led, mdl_ctrl);
            end
        end
    endtask

    task automatic test_reset_abort();
        logic [1:0] r;
        int         lat;
        axi_write(32'h0, 32'h1, 4'h1, 0, 0, 0, r, lat);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        mdl_ctrl = 1'b0; mdl_scratch = 32'd0;
        vectors++;
        if ({s_bvalid, s_awready, s_wready, led} !== 4'b0110) begin
            miscompares++;
            $display("FAIL reset_abort: got %b expected 0110", {s_bvalid, s_awready, s_wready, led});
        end
        repeat (3) @(negedge clk);
        vectors++;
        if (s_bvalid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_abort_no_resp: got %b expected 0", s_bvalid);
        end
    endtask

    initial begin
        rst = 1'b1;
        s_awaddr = '0; s_awvalid = 1'b0; s_wdata = '0; s_wstrb = '0; s_wvalid = 1'b0;
        s_bready = 1'b0; s_araddr = '0; s_arvalid = 1'b0; s_rready = 1'b0;
        mdl_ctrl = 1'b0; mdl_scratch = 32'd0;
        @(negedge clk);
        test_reset();
        test_split_write();
        test_strobe();
        test_led();
        test_back_pressure();
        test_unmapped();
        test_simultaneous();
        test_random();
        test_reset_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
